// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared store-size encodings, serializer states and size helpers
//
// Purpose: constants and helpers shared by the memory-stage store path.
//   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL : req_size encodings
//   store_state_e                        : serializer FSM states
//   byte_count()                         : bytes written for a size (0 for illegal)
//   store_is_legal()                     : size legal and address naturally aligned
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } store_state_e;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Only the two low address bits matter for natural alignment.
  function automatic logic store_is_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return (addr_lo[0] == 1'b0);
      SZ_WORD: return (addr_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_byte_select.sv
// rtl/store_byte_select.sv - big-endian byte picker for the store serializer
//
// Purpose: combinationally selects the byte to write for a given beat.
// Ports:
//   data     in  32  captured register value
//   size     in  2   captured size encoding
//   index    in  2   beat index (0 = first byte written, most significant)
//   byte_out out 8   byte for this beat; 0 for the illegal size
module store_byte_select
  import mips_mem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  index,
  output logic [7:0]  byte_out
);

  logic [2:0] lane_wide;
  logic [1:0] lane;

  // Beat 0 takes the most significant byte of the narrowed value, so the
  // register lane counts down from N-1 as the beat index counts up.
  always_comb begin
    lane_wide = byte_count(size) - 3'd1 - {1'b0, index};
    lane      = lane_wide[1:0];
    byte_out  = 8'h00;
    if (size != SZ_ILL) begin
      case (lane)
        2'd0:    byte_out = data[7:0];
        2'd1:    byte_out = data[15:8];
        2'd2:    byte_out = data[23:16];
        default: byte_out = data[31:24];
      endcase
    end
  end

endmodule

// File: rtl/store_byte_serializer.sv
// rtl/store_byte_serializer.sv - serializes SB/SH/SW stores into big-endian byte writes
//
// Purpose: accepts one store from the memory stage, checks size and alignment,
// then emits one byte write per acknowledged beat and pulses done (with err on
// a rejected store). Holds req_ready low while busy to stall the pipeline.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req_valid/req_ready store request handshake (ready only in IDLE)
//   req_addr/data/size  store byte address, rt value, size encoding
//   mem_we/addr/wdata   byte write to data memory, held until mem_ack
//   mem_ack             memory accepts the current byte
//   done/err            one-cycle completion pulse; err marks a rejected store
module store_byte_serializer
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);

  store_state_e      state;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_data;
  logic [1:0]        cap_size;
  logic [1:0]        idx;
  logic              last_byte;

  assign last_byte = ({1'b0, idx} == (byte_count(cap_size) - 3'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      idx       <= 2'd0;
      cap_addr  <= '0;
      cap_data  <= 32'h0;
      cap_size  <= SZ_BYTE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_addr  <= req_addr;
            cap_data  <= req_data;
            cap_size  <= req_size;
            idx       <= 2'd0;
            req_ready <= 1'b0;
            if (store_is_legal(req_size, req_addr[1:0])) begin
              state  <= ST_WRITE;
              mem_we <= 1'b1;
              err    <= 1'b0;
            end else begin
              // Rejected stores skip WRITE entirely: no byte reaches memory.
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // Without an ack every output holds, so the memory can stall freely.
          if (mem_ack) begin
            if (last_byte) begin
              state  <= ST_DONE;
              mem_we <= 1'b0;
              done   <= 1'b1;
              err    <= 1'b0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          mem_we    <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Address and data are decoded from captured state only, never from req_*.
  assign mem_addr = cap_addr + ADDR_W'(idx);

  store_byte_select u_byte_select (
    .data     (cap_data),
    .size     (cap_size),
    .index    (idx),
    .byte_out (mem_wdata)
  );

endmodule

// File: tb/tb_store_byte_serializer.sv
// tb/tb_store_byte_serializer.sv - self-checking bench for store_byte_serializer
module tb_store_byte_serializer;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  store_byte_serializer #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: expected byte writes and error flag for one store.
  logic [ADDR_W-1:0] exp_addr[$];
  logic [7:0]        exp_data[$];
  logic              exp_err;

  task automatic model(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [1:0] s);
    int n;
    exp_addr.delete();
    exp_data.delete();
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    exp_err = (s == 2'd3) || ((a % n) != 0);
    if (!exp_err)
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(a + ADDR_W'(i));
        exp_data.push_back(8'((d >> (8 * (n - 1 - i))) & 32'hff));
      end
  endtask

  // Observations gathered while driving one store.
  logic [ADDR_W-1:0] obs_addr[$];
  logic [7:0]        obs_data[$];
  int                obs_done_cyc;
  int                obs_we_cyc;
  int                obs_hold_viol;
  logic              obs_err;
  logic              obs_ready_after;
  bit                obs_timeout;

  // Entered #1 after a rising edge with the DUT idle; returns likewise.
  task automatic run_store(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input logic [1:0] s, input int stall_first, input bit rand_ack);
    int   cyc;
    int   lows;
    bit   prev_stalled;
    logic [ADDR_W-1:0] prev_a;
    logic [7:0]        prev_d;
    obs_addr.delete();
    obs_data.delete();
    obs_done_cyc  = -1;
    obs_we_cyc    = 0;
    obs_hold_viol = 0;
    obs_err       = 1'b0;
    obs_timeout   = 1'b0;
    prev_stalled  = 1'b0;
    prev_a        = '0;
    prev_d        = 8'h00;
    lows          = stall_first;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    mem_ack   = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready got=%b want=1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_size  = 2'($urandom);
    cyc = 1;
    while (1) begin
      if (mem_we) begin
        obs_we_cyc++;
        if (prev_stalled && (mem_addr !== prev_a || mem_wdata !== prev_d))
          obs_hold_viol++;
        if (lows > 0) begin
          mem_ack = 1'b0;
          lows--;
        end else begin
          mem_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (mem_ack) begin
          obs_addr.push_back(mem_addr);
          obs_data.push_back(mem_wdata);
        end
        prev_stalled = !mem_ack;
        prev_a       = mem_addr;
        prev_d       = mem_wdata;
      end else begin
        mem_ack      = 1'($urandom_range(0, 1));
        prev_stalled = 1'b0;
      end
      if (done === 1'b1) begin
        obs_done_cyc = cyc;
        obs_err      = err;
        break;
      end
      if (cyc > 200) begin
        obs_timeout = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_ack = 1'b0;
    @(posedge clk); #1;
    obs_ready_after = req_ready;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    req_data  = 32'hDEAD_BEEF;
    req_size  = 2'd2;
    mem_ack   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got ready=%b we=%b done=%b err=%b want 1 0 0 0",
               req_ready, mem_we, done, err);
    end
    total++;
    if (mem_addr !== '0 || mem_wdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata);
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    reset     = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    model(32'h100, 32'hDEAD_BEEF, 2'd2);
    run_store(32'h100, 32'hDEAD_BEEF, 2'd2, 0, 1'b0);
    total++;
    if (obs_timeout || obs_done_cyc != 5 || obs_err !== 1'b0) begin
      bad++;
      $display("FAIL sw_done got cyc=%0d err=%b to=%0d want cyc=5 err=0", obs_done_cyc, obs_err, obs_timeout);
    end
    total++;
    if (obs_addr.size() != exp_addr.size()) begin
      bad++;
      $display("FAIL sw_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++;
          $display("FAIL sw_byte%0d got=(%h,%h) want=(%h,%h)", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    total++;
    if (obs_ready_after !== 1'b1) begin
      bad++;
      $display("FAIL sw_ready_return got=%b want=1", obs_ready_after);
    end
  endtask

  task automatic test_half();
    model(32'h202, 32'hFFFF_8001, 2'd1);
    run_store(32'h202, 32'hFFFF_8001, 2'd1, 0, 1'b0);
    total++;
    if (obs_timeout || obs_done_cyc != 3 || obs_err !== 1'b0 || obs_we_cyc != 2) begin
      bad++;
      $display("FAIL sh_done got cyc=%0d err=%b we=%0d want cyc=3 err=0 we=2", obs_done_cyc, obs_err, obs_we_cyc);
    end
    total++;
    if (obs_addr.size() != exp_addr.size()) begin
      bad++;
      $display("FAIL sh_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++;
          $display("FAIL sh_byte%0d got=(%h,%h) want=(%h,%h)", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_byte_stall();
    model(32'h33, 32'h1234_56F6, 2'd0);
    run_store(32'h33, 32'h1234_56F6, 2'd0, 3, 1'b0);
    total++;
    if (obs_timeout || obs_we_cyc != 4 || obs_done_cyc != 5 || obs_hold_viol != 0) begin
      bad++;
      $display("FAIL sb_stall got we=%0d done_cyc=%0d hold_viol=%0d want we=4 done_cyc=5 hold_viol=0",
               obs_we_cyc, obs_done_cyc, obs_hold_viol);
    end
    total++;
    if (obs_addr.size() != 1 || obs_addr[0] !== exp_addr[0] || obs_data[0] !== exp_data[0]) begin
      bad++;
      $display("FAIL sb_byte got n=%0d want (%h,%h)", obs_addr.size(), exp_addr[0], exp_data[0]);
    end
  endtask

  task automatic test_errors();
    logic [ADDR_W-1:0] a_tab[3] = '{32'h102, 32'h201, 32'h40};
    logic [1:0]        s_tab[3] = '{2'd2, 2'd1, 2'd3};
    for (int k = 0; k < 3; k++) begin
      run_store(a_tab[k], $urandom, s_tab[k], 0, 1'b1);
      total++;
      if (obs_timeout || obs_done_cyc != 1 || obs_err !== 1'b1 || obs_we_cyc != 0) begin
        bad++;
        $display("FAIL err_case%0d got cyc=%0d err=%b we=%0d want cyc=1 err=1 we=0",
                 k, obs_done_cyc, obs_err, obs_we_cyc);
      end
      total++;
      if (obs_ready_after !== 1'b1) begin
        bad++;
        $display("FAIL err_ready%0d got=%b want=1", k, obs_ready_after);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    int dones;
    req_valid = 1'b1;
    req_addr  = 32'h40;
    req_data  = $urandom;
    req_size  = 2'd2;
    mem_ack   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h40) begin
      bad++;
      $display("FAIL rst_mid_first got we=%b addr=%h want 1 40", mem_we, mem_addr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    mem_ack = 1'b0;
    total++;
    if (mem_we !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_idle got we=%b done=%b ready=%b want 0 0 1", mem_we, done, req_ready);
    end
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1 || mem_we === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL rst_mid_quiet got activity=%0d want=0", dones);
    end
    model(32'h77, 32'hCAFE_F00D, 2'd0);
    run_store(32'h77, 32'hCAFE_F00D, 2'd0, 0, 1'b0);
    total++;
    if (obs_done_cyc != 2 || obs_addr.size() != 1 || obs_addr[0] !== exp_addr[0] || obs_data[0] !== exp_data[0]) begin
      bad++;
      $display("FAIL rst_mid_sb got cyc=%0d n=%0d want cyc=2 (%h,%h)", obs_done_cyc, obs_addr.size(), exp_addr[0], exp_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] ea_a[$];
    logic [7:0]        ea_d[$];
    logic [31:0]       da;
    logic [31:0]       db;
    int cyc;
    int acc_cyc;
    int done_b;
    da = $urandom;
    db = $urandom;
    model(32'h10, da, 2'd1);
    ea_a = exp_addr;
    ea_d = exp_data;
    obs_addr.delete();
    obs_data.delete();
    req_valid = 1'b1;
    req_addr  = 32'h10;
    req_data  = da;
    req_size  = 2'd1;
    mem_ack   = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h20;
    req_data = db;
    req_size = 2'd2;
    acc_cyc = -1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (req_ready === 1'b1) begin
        acc_cyc = cyc;
        break;
      end
      if (mem_we) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_wdata);
      end
      @(posedge clk); #1;
    end
    total++;
    if (acc_cyc != 4) begin
      bad++;
      $display("FAIL b2b_accept got ready_cyc=%0d want=4", acc_cyc);
    end
    total++;
    if (obs_addr.size() != 2 || obs_addr[0] !== ea_a[0] || obs_data[0] !== ea_d[0] ||
        obs_addr[1] !== ea_a[1] || obs_data[1] !== ea_d[1]) begin
      bad++;
      $display("FAIL b2b_first got n=%0d want (%h,%h)(%h,%h)", obs_addr.size(), ea_a[0], ea_d[0], ea_a[1], ea_d[1]);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    model(32'h20, db, 2'd2);
    obs_addr.delete();
    obs_data.delete();
    done_b = -1;
    for (int k = 1; k <= 20; k++) begin
      if (mem_we) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_wdata);
      end
      if (done === 1'b1) begin
        done_b = k;
        break;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    total++;
    if (done_b != 5 || obs_addr.size() != 4) begin
      bad++;
      $display("FAIL b2b_second got done=%0d n=%0d want done=5 n=4", done_b, obs_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++;
          $display("FAIL b2b_byte%0d got=(%h,%h) want=(%h,%h)", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [1:0]        s;
    for (int it = 0; it < 30; it++) begin
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d = $urandom;
      model(a, d, s);
      run_store(a, d, s, $urandom_range(0, 2), 1'b1);
      total++;
      if (obs_timeout || obs_err !== exp_err || obs_done_cyc != obs_we_cyc + 1 || obs_ready_after !== 1'b1) begin
        bad++;
        $display("FAIL rand%0d got err=%b done_cyc=%0d we=%0d ready=%b want err=%b done_cyc=we+1 ready=1",
                 it, obs_err, obs_done_cyc, obs_we_cyc, obs_ready_after, exp_err);
      end
      total++;
      if (obs_addr.size() != exp_addr.size()) begin
        bad++;
        $display("FAIL rand%0d_count got=%0d want=%0d", it, obs_addr.size(), exp_addr.size());
      end else begin
        foreach (exp_addr[i]) begin
          total++;
          if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            bad++;
            $display("FAIL rand%0d_byte%0d got=(%h,%h) want=(%h,%h)", it, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = 32'h0;
    req_size  = 2'd0;
    mem_ack   = 1'b0;
    test_reset();
    test_word();
    test_half();
    test_byte_stall();
    test_errors();
    test_reset_midwrite();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
